// File: rtl/key_debounce_ctrl.sv
// -----------------------------------------------------------------------------
// key_debounce_ctrl
//
// Debounces KEY_COUNT independent active-low push buttons. Each channel has
// its own 2-flop synchronizer, four-state FSM, debounce counter and hold
// counter. The channels share nothing except the clock and reset.
//
// Ports
//   EXTCLK       in   1          system clock, rising edge only
//   RST          in   1          synchronous active-high reset
//   KEY          in   KEY_COUNT  raw buttons, 0 = pressed, asynchronous
//   key_level    out  KEY_COUNT  debounced state, 1 = pressed
//   key_press    out  KEY_COUNT  one-cycle pulse on an accepted press
//   key_release  out  KEY_COUNT  one-cycle pulse on an accepted release
//   key_long     out  KEY_COUNT  one-cycle pulse once a press is held
//                                LONG_CYCLES clocks
//   key_toggle   out  KEY_COUNT  inverts on every accepted press
//   o_state_dbg  out  2*KEY_COUNT  per-channel FSM state, channel g in
//                                bits [2*g+1:2*g] (IDLE=0, PRESS_WAIT=1,
//                                HELD=2, RELEASE_WAIT=3)
//
// Timing: a raw edge first sampled at clock edge N reaches the FSM at edge
// N+2 and is accepted at edge N+DEBOUNCE_CYCLES+2, so the corresponding
// pulse is visible in the cycle that follows that edge.
// -----------------------------------------------------------------------------
module key_debounce_ctrl #(
  parameter int KEY_COUNT       = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic                   EXTCLK,
  input  logic                   RST,
  input  logic [KEY_COUNT-1:0]   KEY,
  output logic [KEY_COUNT-1:0]   key_level,
  output logic [KEY_COUNT-1:0]   key_press,
  output logic [KEY_COUNT-1:0]   key_release,
  output logic [KEY_COUNT-1:0]   key_long,
  output logic [KEY_COUNT-1:0]   key_toggle,
  output logic [2*KEY_COUNT-1:0] o_state_dbg
);

  // Counter widths hold values 0..PARAM-1; never narrower than one bit.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_ONE  = LG_W'(1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  // Synchronizer: invert first so that 1 means pressed from here on.
  logic [KEY_COUNT-1:0] r_sync_meta;
  logic [KEY_COUNT-1:0] r_sync;

  always_ff @(posedge EXTCLK) begin
    if (RST) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= ~KEY;
      r_sync      <= r_sync_meta;
    end
  end

  for (genvar g = 0; g < KEY_COUNT; g++) begin : g_ch
    state_t          r_state;
    logic [DB_W-1:0] r_db_cnt;
    logic [LG_W-1:0] r_hold_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;
    logic            r_long;
    logic            r_toggle;
    logic            w_sync;

    assign w_sync = r_sync[g];

    always_ff @(posedge EXTCLK) begin
      if (RST) begin
        r_state    <= ST_IDLE;
        r_db_cnt   <= '0;
        r_hold_cnt <= '0;
        r_level    <= 1'b0;
        r_press    <= 1'b0;
        r_release  <= 1'b0;
        r_long     <= 1'b0;
        r_toggle   <= 1'b0;
      end else begin
        // Event outputs are single-cycle pulses.
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        case (r_state)
          ST_IDLE: begin
            if (w_sync) begin
              r_state  <= ST_PRESS_WAIT;
              r_db_cnt <= '0;
            end
          end
          ST_PRESS_WAIT: begin
            if (!w_sync) begin
              r_state <= ST_IDLE;
            end else if (r_db_cnt == DB_LAST) begin
              r_state    <= ST_HELD;
              r_level    <= 1'b1;
              r_press    <= 1'b1;
              r_toggle   <= ~r_toggle;
              r_hold_cnt <= '0;
            end else begin
              r_db_cnt <= r_db_cnt + DB_ONE;
            end
          end
          ST_HELD: begin
            if (!w_sync) begin
              r_state  <= ST_RELEASE_WAIT;
              r_db_cnt <= '0;
            end else if (r_hold_cnt != LG_LAST) begin
              // Saturating count; the long pulse fires only on the step
              // that lands on the last value, so it can happen once per press.
              r_hold_cnt <= r_hold_cnt + LG_ONE;
              if (r_hold_cnt == LG_LAST - LG_ONE) begin
                r_long <= 1'b1;
              end
            end
          end
          ST_RELEASE_WAIT: begin
            if (w_sync) begin
              // Bounce during release: back to HELD, hold count kept.
              r_state <= ST_HELD;
            end else if (r_db_cnt == DB_LAST) begin
              r_state   <= ST_IDLE;
              r_level   <= 1'b0;
              r_release <= 1'b1;
            end else begin
              r_db_cnt <= r_db_cnt + DB_ONE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end

    assign key_level[g]          = r_level;
    assign key_press[g]          = r_press;
    assign key_release[g]        = r_release;
    assign key_long[g]           = r_long;
    assign key_toggle[g]         = r_toggle;
    assign o_state_dbg[2*g +: 2] = r_state;
  end

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_ctrl
//
// Directed bench for key_debounce_ctrl with DEBOUNCE_CYCLES=8, LONG_CYCLES=40,
// KEY_COUNT=2. Inputs change on the falling edge; outputs are sampled on the
// falling edge. Whenever a raw key change is driven, the pulse it must cause
// is pushed into exp_q tagged with the cycle it must appear in; a monitor
// pops and compares every pulse the DUT produces.
// -----------------------------------------------------------------------------
module tb_key_debounce_ctrl;

  localparam int KC  = 2;
  localparam int DB  = 8;
  localparam int LG  = 40;
  localparam int W   = 32;
  localparam int LAT = DB + 3;   // drive at cycle c -> pulse seen at cycle c+LAT

  localparam int T_PRESS   = 0;
  localparam int T_RELEASE = 1;
  localparam int T_LONG    = 2;

  logic          clk;
  logic          rst;
  logic [KC-1:0] key;
  logic [KC-1:0] key_level;
  logic [KC-1:0] key_press;
  logic [KC-1:0] key_release;
  logic [KC-1:0] key_long;
  logic [KC-1:0] key_toggle;
  logic [2*KC-1:0] state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [KC-1:0] exp_toggle;

  key_debounce_ctrl #(
    .KEY_COUNT      (KC),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG)
  ) dut (
    .EXTCLK     (clk),
    .RST        (rst),
    .KEY        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_toggle (key_toggle),
    .o_state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input int c, input int t, input int ch);
    return (W'(c) << 4) | (W'(t) << 2) | W'(ch);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int t, input int ch);
    exp_q.push_back(ev(c, t, ch));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int ch = 0; ch < KC; ch++) begin
      for (int t = 0; t < 3; t++) begin
        logic hit;
        hit = (t == T_PRESS) ? key_press[ch] :
              (t == T_RELEASE) ? key_release[ch] : key_long[ch];
        if (hit === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", ev(cyc, t, ch), '1);
          end else begin
            check("event", ev(cyc, t, ch), exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    key = '0;
    exp_toggle = '0;

    // Reset with both keys already pressed: outputs held at zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs", W'({key_level, key_press, key_release, key_long, key_toggle}), '0);
    end
    rst = 1'b0;
    push(cyc + LAT, T_PRESS, 0);
    push(cyc + LAT, T_PRESS, 1);
    exp_toggle = 2'b11;
    wait_cycles(20);
    check("both_level", W'(key_level), W'(2'b11));
    check("both_toggle", W'(key_toggle), W'(exp_toggle));
    key = 2'b11;
    push(cyc + LAT, T_RELEASE, 0);
    push(cyc + LAT, T_RELEASE, 1);
    wait_cycles(20);
    check("both_released", W'(key_level), W'(2'b00));

    // Clean press of key 0.
    key[0] = 1'b0;
    push(cyc + LAT, T_PRESS, 0);
    exp_toggle[0] = ~exp_toggle[0];
    wait_cycles(15);
    check("k0_level", W'(key_level[0]), W'(1'b1));
    check("k0_toggle", W'(key_toggle), W'(exp_toggle));
    key[0] = 1'b1;
    push(cyc + LAT, T_RELEASE, 0);
    wait_cycles(15);
    check("k0_release_level", W'(key_level[0]), W'(1'b0));

    // Short glitches must be rejected.
    for (int i = 0; i < 4; i++) begin
      key[0] = 1'b0;
      wait_cycles(DB - 3);
      key[0] = 1'b1;
      wait_cycles(5);
      check("glitch_level", W'(key_level[0]), W'(1'b0));
    end
    wait_cycles(10);
    check("glitch_toggle", W'(key_toggle), W'(exp_toggle));

    // Long press of key 1: one long pulse LG-1 cycles after the press.
    key[1] = 1'b0;
    push(cyc + LAT, T_PRESS, 1);
    push(cyc + LAT + LG - 1, T_LONG, 1);
    exp_toggle[1] = ~exp_toggle[1];
    wait_cycles(60);
    check("k1_long_level", W'(key_level[1]), W'(1'b1));
    key[1] = 1'b1;
    push(cyc + LAT, T_RELEASE, 1);
    wait_cycles(40);
    check("k1_after_release", W'(key_level[1]), W'(1'b0));

    // Release bounce while HELD must not produce a release.
    key[0] = 1'b0;
    push(cyc + LAT, T_PRESS, 0);
    exp_toggle[0] = ~exp_toggle[0];
    wait_cycles(20);
    key[0] = 1'b1;
    wait_cycles(3);
    key[0] = 1'b0;
    wait_cycles(8);
    check("bounce_level", W'(key_level[0]), W'(1'b1));
    key[0] = 1'b1;
    push(cyc + LAT, T_RELEASE, 0);
    wait_cycles(15);
    check("bounce_released", W'(key_level[0]), W'(1'b0));

    // Two full presses: toggle flips twice.
    for (int i = 0; i < 2; i++) begin
      key[0] = 1'b0;
      push(cyc + LAT, T_PRESS, 0);
      exp_toggle[0] = ~exp_toggle[0];
      wait_cycles(15);
      check("twice_toggle", W'(key_toggle), W'(exp_toggle));
      key[0] = 1'b1;
      push(cyc + LAT, T_RELEASE, 0);
      wait_cycles(15);
    end

    // Reset in the middle of PRESS_WAIT: no pulse, then a fresh debounce.
    key[0] = 1'b0;
    wait_cycles(6);
    rst = 1'b1;
    wait_cycles(2);
    check("midreset_outputs", W'({key_level, key_press, key_release, key_long, key_toggle}), '0);
    rst = 1'b0;
    exp_toggle = '0;
    push(cyc + LAT, T_PRESS, 0);
    exp_toggle[0] = 1'b1;
    wait_cycles(15);
    check("fresh_press_level", W'(key_level[0]), W'(1'b1));
    check("fresh_press_toggle", W'(key_toggle), W'(exp_toggle));
    key[0] = 1'b1;
    push(cyc + LAT, T_RELEASE, 0);
    wait_cycles(20);

    check("queue_drained", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
